// File: rtl/sys_defs.sv
// Shared system definitions: fetch/dispatch packet type, NOP encoding and
// the system-wide instruction buffer depth.
package sys_defs;

  // Default number of instruction buffer entries (power of two, >= 2).
  localparam int IB_DEPTH = 8;

  // Canonical no-op instruction word (addi x0, x0, 0).
  localparam logic [31:0] NOP = 32'h0000_0013;

  // Packet handed from fetch to the instruction buffer and on to dispatch.
  typedef struct packed {
    logic        valid;
    logic [31:0] inst;
    logic [31:0] NPC;
    logic [31:0] PC;
    logic        pred_bp_taken;
  } IF_IB_PACKET;

  // Packet presented to dispatch when nothing is available: all zero, NOP inst.
  function automatic IF_IB_PACKET ib_empty_packet();
    IF_IB_PACKET p;
    p      = '0;
    p.inst = NOP;
    return p;
  endfunction

endpackage

// File: rtl/inst_buffer.sv
// Instruction buffer: circular FIFO between fetch and dispatch.
// Accepts one packet per cycle, presents the oldest entry, back-pressures
// fetch with ib_full and drops everything on flush.
// Optional feature macro: IB_BYPASS_EN -- when the buffer is empty an
// incoming packet is forwarded combinationally to dispatch.
module inst_buffer
  import sys_defs::*;
#(
  parameter int DEPTH = IB_DEPTH
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         flush,
  input  IF_IB_PACKET                  if_ib_packet,
  input  logic                         dp_ready,
  output IF_IB_PACKET                  ib_dp_packet,
  output logic                         ib_full,
  output logic [$clog2(DEPTH+1)-1:0]   ib_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  IF_IB_PACKET         mem_reg [DEPTH];
  logic [PW-1:0]       head_reg;
  logic [PW-1:0]       tail_reg;
  logic [CW-1:0]       count_reg;

  logic                stored_valid;
  logic                bypass_active;
  logic                push;
  logic                pop;
  logic                do_write;
  logic                do_pop;

  assign stored_valid = (count_reg != '0);
  assign ib_full      = (count_reg == CW'(DEPTH));
  assign ib_count     = count_reg;

`ifdef IB_BYPASS_EN
  // Empty buffer with a live fetch packet: forward it straight to dispatch.
  assign bypass_active = !stored_valid && if_ib_packet.valid && !flush;
`else
  assign bypass_active = 1'b0;
`endif

  // Head presentation: stored head, bypassed packet, or the empty NOP packet.
  always_comb begin
    ib_dp_packet = ib_empty_packet();
    if (!flush) begin
      if (stored_valid) begin
        ib_dp_packet       = mem_reg[head_reg];
        ib_dp_packet.valid = 1'b1;
      end else if (bypass_active) begin
        ib_dp_packet = if_ib_packet;
      end
    end
  end

  // Handshakes; a bypassed packet taken by dispatch is neither written nor popped.
  always_comb begin
    push     = if_ib_packet.valid && !ib_full && !flush;
    pop      = ib_dp_packet.valid && dp_ready && !flush;
    do_write = push;
    do_pop   = pop;
    if (bypass_active && dp_ready) begin
      do_write = 1'b0;
      do_pop   = 1'b0;
    end
  end

  // Pointer and occupancy state; flush and reset both empty the buffer.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else if (flush) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      if (do_pop) begin
        head_reg <= head_reg + PW'(1);
      end
      if (do_write) begin
        tail_reg <= tail_reg + PW'(1);
      end
      count_reg <= count_reg + CW'(do_write) - CW'(do_pop);
    end
  end

  // Entry storage; contents are don't-care once pointers are cleared.
  always_ff @(posedge clock) begin
    if (do_write) begin
      mem_reg[tail_reg] <= if_ib_packet;
    end
  end

endmodule

// File: tb/tb_inst_buffer.sv
// Self-checking bench for inst_buffer (DEPTH=4) with a scoreboard queue of
// expected PCs. Define IB_BYPASS_EN on both bench and RTL to cover bypass.
module tb_inst_buffer;
  import sys_defs::*;

  localparam int DEPTH = 4;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        flush = 1'b0;
  logic        dp_ready = 1'b0;
  IF_IB_PACKET if_ib_packet = '0;
  IF_IB_PACKET ib_dp_packet;
  logic        ib_full;
  logic [2:0]  ib_count;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] sb_q[$];

  logic        popped;
  IF_IB_PACKET exp_pkt;
  IF_IB_PACKET got_pkt;

  inst_buffer #(.DEPTH(DEPTH)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .flush       (flush),
    .if_ib_packet(if_ib_packet),
    .dp_ready    (dp_ready),
    .ib_dp_packet(ib_dp_packet),
    .ib_full     (ib_full),
    .ib_count    (ib_count)
  );

  always #5 clock = ~clock;

  function automatic IF_IB_PACKET mk(input logic [31:0] pc);
    IF_IB_PACKET p;
    p.valid         = 1'b1;
    p.PC            = pc;
    p.NPC           = pc + 32'd4;
    p.inst          = pc ^ 32'h5A5A_0000;
    p.pred_bp_taken = pc[3];
    return p;
  endfunction

  function automatic IF_IB_PACKET empty_pkt();
    IF_IB_PACKET p;
    p      = '0;
    p.inst = NOP;
    return p;
  endfunction

  // Drive one cycle of inputs at the falling edge, sample the head, update model.
  task automatic apply(input logic v, input logic [31:0] pc, input logic rdy,
                       input logic fl, output logic pop_o,
                       output IF_IB_PACKET exp_o, output IF_IB_PACKET got_o);
    bit full_m;
    bit byp;
    @(negedge clock);
    if_ib_packet = v ? mk(pc) : '0;
    dp_ready     = rdy;
    flush        = fl;
    #1;
    got_o  = ib_dp_packet;
    exp_o  = empty_pkt();
    pop_o  = 1'b0;
    full_m = (sb_q.size() == DEPTH);
    byp    = 1'b0;
`ifdef IB_BYPASS_EN
    byp = (sb_q.size() == 0) && v && !fl;
`endif
    if (fl) begin
      sb_q.delete();
    end else if (byp) begin
      pop_o = rdy;
      exp_o = mk(pc);
      if (!rdy) sb_q.push_back(pc);
    end else begin
      if (rdy && sb_q.size() > 0) begin
        pop_o = 1'b1;
        exp_o = mk(sb_q.pop_front());
      end
      if (v && !full_m) sb_q.push_back(pc);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clock);
    #1;
    n_checks++;
    if (ib_count !== 3'd0) begin
      n_fail++; $display("FAIL reset_count: got %0d want 0", ib_count);
    end
    n_checks++;
    if (ib_full !== 1'b0) begin
      n_fail++; $display("FAIL reset_full: got %b want 0", ib_full);
    end
    n_checks++;
    if (ib_dp_packet !== empty_pkt()) begin
      n_fail++; $display("FAIL reset_packet: got %h want %h", ib_dp_packet, empty_pkt());
    end
    @(negedge clock);
    reset_n = 1'b1;
    $display("reset: count=%0d full=%b valid=%b", ib_count, ib_full, ib_dp_packet.valid);
  endtask

  task automatic test_fill_and_drain();
    apply(1, 32'h0, 0, 0, popped, exp_pkt, got_pkt);
    apply(1, 32'h4, 0, 0, popped, exp_pkt, got_pkt);
    apply(1, 32'h8, 0, 0, popped, exp_pkt, got_pkt);
    apply(0, 32'h0, 0, 0, popped, exp_pkt, got_pkt);
    $display("fill3: count=%0d full=%b head_pc=%h", ib_count, ib_full, got_pkt.PC);
    n_checks++;
    if (ib_count !== 3'd3) begin
      n_fail++; $display("FAIL fill3_count: got %0d want 3", ib_count);
    end
    n_checks++;
    if (ib_full !== 1'b0) begin
      n_fail++; $display("FAIL fill3_full: got %b want 0", ib_full);
    end
    n_checks++;
    if (got_pkt !== mk(32'h0)) begin
      n_fail++; $display("FAIL fill3_head: got %h want %h", got_pkt, mk(32'h0));
    end
    apply(1, 32'hC, 0, 0, popped, exp_pkt, got_pkt);
    apply(0, 32'h0, 0, 0, popped, exp_pkt, got_pkt);
    $display("fill4: count=%0d full=%b", ib_count, ib_full);
    n_checks++;
    if (ib_full !== 1'b1 || ib_count !== 3'd4) begin
      n_fail++; $display("FAIL fill4_full: got full=%b count=%0d want full=1 count=4", ib_full, ib_count);
    end
    apply(1, 32'h10, 0, 0, popped, exp_pkt, got_pkt);
    apply(0, 32'h0, 0, 0, popped, exp_pkt, got_pkt);
    $display("push_when_full: count=%0d", ib_count);
    n_checks++;
    if (ib_count !== 3'd4) begin
      n_fail++; $display("FAIL full_push_dropped: got count %0d want 4", ib_count);
    end
    for (int i = 0; i < 4; i++) begin
      apply(0, 32'h0, 1, 0, popped, exp_pkt, got_pkt);
      $display("drain[%0d]: got_pc=%h exp_pc=%h", i, got_pkt.PC, exp_pkt.PC);
      n_checks++;
      if (!popped || got_pkt !== exp_pkt) begin
        n_fail++; $display("FAIL drain_order[%0d]: got %h want %h", i, got_pkt, exp_pkt);
      end
    end
    apply(0, 32'h0, 0, 0, popped, exp_pkt, got_pkt);
    n_checks++;
    if (got_pkt !== empty_pkt() || ib_count !== 3'd0) begin
      n_fail++; $display("FAIL drained_empty: got %h count %0d want %h count 0", got_pkt, ib_count, empty_pkt());
    end
  endtask

  task automatic test_wrap();
    apply(1, 32'h1000, 0, 0, popped, exp_pkt, got_pkt);
    for (int i = 1; i <= 10; i++) begin
      apply(1, 32'h1000 + 32'(4 * i), 1, 0, popped, exp_pkt, got_pkt);
      $display("wrap[%0d]: got_pc=%h exp_pc=%h count=%0d", i, got_pkt.PC, exp_pkt.PC, ib_count);
      n_checks++;
      if (!popped || got_pkt !== exp_pkt) begin
        n_fail++; $display("FAIL wrap_data[%0d]: got %h want %h", i, got_pkt, exp_pkt);
      end
      n_checks++;
      if (ib_count !== 3'd1) begin
        n_fail++; $display("FAIL wrap_count[%0d]: got %0d want 1", i, ib_count);
      end
    end
    apply(0, 32'h0, 1, 0, popped, exp_pkt, got_pkt);
    n_checks++;
    if (!popped || got_pkt !== exp_pkt) begin
      n_fail++; $display("FAIL wrap_tail: got %h want %h", got_pkt, exp_pkt);
    end
    apply(0, 32'h0, 0, 0, popped, exp_pkt, got_pkt);
    n_checks++;
    if (ib_count !== 3'(sb_q.size())) begin
      n_fail++; $display("FAIL wrap_end_count: got %0d want %0d", ib_count, sb_q.size());
    end
  endtask

  task automatic test_flush();
    apply(1, 32'h300, 0, 0, popped, exp_pkt, got_pkt);
    apply(1, 32'h304, 0, 0, popped, exp_pkt, got_pkt);
    apply(1, 32'h308, 0, 0, popped, exp_pkt, got_pkt);
    apply(1, 32'h30C, 1, 1, popped, exp_pkt, got_pkt);
    $display("flush_cycle: count=%0d valid=%b", ib_count, got_pkt.valid);
    n_checks++;
    if (got_pkt.valid !== 1'b0) begin
      n_fail++; $display("FAIL flush_cycle_valid: got %b want 0", got_pkt.valid);
    end
    apply(0, 32'h0, 0, 0, popped, exp_pkt, got_pkt);
    $display("after_flush: count=%0d valid=%b", ib_count, got_pkt.valid);
    n_checks++;
    if (ib_count !== 3'd0 || got_pkt.valid !== 1'b0) begin
      n_fail++; $display("FAIL after_flush: got count %0d valid %b want 0 0", ib_count, got_pkt.valid);
    end
    apply(1, 32'h400, 0, 0, popped, exp_pkt, got_pkt);
    apply(0, 32'h0, 1, 0, popped, exp_pkt, got_pkt);
    $display("post_flush_pop: got_pc=%h exp_pc=%h", got_pkt.PC, exp_pkt.PC);
    n_checks++;
    if (!popped || got_pkt !== exp_pkt) begin
      n_fail++; $display("FAIL post_flush_head: got %h want %h", got_pkt, exp_pkt);
    end
    apply(0, 32'h0, 0, 0, popped, exp_pkt, got_pkt);
  endtask

  task automatic test_async_reset();
    apply(1, 32'h500, 0, 0, popped, exp_pkt, got_pkt);
    apply(1, 32'h504, 0, 0, popped, exp_pkt, got_pkt);
    apply(0, 32'h0, 0, 0, popped, exp_pkt, got_pkt);
    n_checks++;
    if (ib_count !== 3'd2) begin
      n_fail++; $display("FAIL pre_reset_count: got %0d want 2", ib_count);
    end
    #1;
    reset_n = 1'b0;
    sb_q.delete();
    #1;
    $display("async_reset: count=%0d valid=%b full=%b", ib_count, ib_dp_packet.valid, ib_full);
    n_checks++;
    if (ib_count !== 3'd0 || ib_dp_packet.valid !== 1'b0 || ib_full !== 1'b0) begin
      n_fail++; $display("FAIL async_reset: got count %0d valid %b full %b want 0 0 0",
                         ib_count, ib_dp_packet.valid, ib_full);
    end
    @(negedge clock);
    reset_n = 1'b1;
    apply(0, 32'h0, 0, 0, popped, exp_pkt, got_pkt);
  endtask

  task automatic test_back_to_back();
    apply(1, 32'h20, 1, 0, popped, exp_pkt, got_pkt);
    $display("empty_push_ready: valid=%b pc=%h", got_pkt.valid, got_pkt.PC);
`ifdef IB_BYPASS_EN
    n_checks++;
    if (!popped || got_pkt !== exp_pkt) begin
      n_fail++; $display("FAIL bypass_data: got %h want %h", got_pkt, exp_pkt);
    end
`else
    n_checks++;
    if (got_pkt.valid !== 1'b0) begin
      n_fail++; $display("FAIL no_bypass_valid: got %b want 0", got_pkt.valid);
    end
`endif
    apply(0, 32'h0, 0, 0, popped, exp_pkt, got_pkt);
    n_checks++;
    if (ib_count !== 3'(sb_q.size())) begin
      n_fail++; $display("FAIL b2b_count: got %0d want %0d", ib_count, sb_q.size());
    end
    apply(0, 32'h0, 1, 0, popped, exp_pkt, got_pkt);
    if (popped) begin
      n_checks++;
      if (got_pkt !== exp_pkt) begin
        n_fail++; $display("FAIL b2b_drain: got %h want %h", got_pkt, exp_pkt);
      end
    end
    apply(0, 32'h0, 0, 0, popped, exp_pkt, got_pkt);
    n_checks++;
    if (ib_count !== 3'd0) begin
      n_fail++; $display("FAIL b2b_end_count: got %0d want 0", ib_count);
    end
  endtask

  initial begin
    test_reset();
    test_fill_and_drain();
    test_wrap();
    test_flush();
    test_async_reset();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
